// File: rtl/ddr2_resp_pkg.sv
`default_nettype none
// =============================================================================
// Module : ddr2_resp_pkg
// Shared types and constants for the DDR2 local-interface responder.
// Rev    : 1.0
// =============================================================================
package ddr2_resp_pkg;

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_IDLE = 2'd1,
        ST_WR   = 2'd2,
        ST_RD   = 2'd3
    } state_t;

    localparam logic [15:0] LFSR_SEED  = 16'hACE1;
    // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10
    localparam logic [15:0] LFSR_TAPS  = 16'hB400;

    localparam int RD_LAT_MIN = 2;
    localparam int RD_LAT_MAX = 15;

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {s[14:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage
`default_nettype wire

// File: rtl/ddr2_resp_rdpipe.sv
`default_nettype none
// =============================================================================
// Module : ddr2_resp_rdpipe
// Backing RAM plus fixed-latency read pipe (index shift register, sync read).
// Rev    : 1.0
// =============================================================================
module ddr2_resp_rdpipe
    import ddr2_resp_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int MEM_AW = 10,
    parameter int RD_LAT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_we,
    input  logic              i_re,
    input  logic [MEM_AW-1:0] i_idx,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata,
    output logic              o_rdata_valid
);

    localparam int c_LAT = (RD_LAT < RD_LAT_MIN) ? RD_LAT_MIN :
                           (RD_LAT > RD_LAT_MAX) ? RD_LAT_MAX : RD_LAT;
    // Index stages ahead of the RAM read; RAM read + output register add two more
    localparam int c_SR  = c_LAT - 1;

    logic [DATA_W-1:0] r_mem [2**MEM_AW];
    logic [c_SR-1:0]   r_v;
    logic [MEM_AW-1:0] r_idx [c_SR];
    logic              r_ram_v;
    logic [DATA_W-1:0] r_ram_q;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_idx] <= i_wdata;
        end
    end

    always_ff @(posedge clk) begin
        r_ram_q <= r_mem[r_idx[c_SR-1]];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v           <= '0;
            r_ram_v       <= 1'b0;
            o_rdata_valid <= 1'b0;
            o_rdata       <= '0;
            for (int k = 0; k < c_SR; k++) begin
                r_idx[k] <= '0;
            end
        end else begin
            r_v[0]   <= i_re;
            r_idx[0] <= i_idx;
            for (int k = 1; k < c_SR; k++) begin
                r_v[k]   <= r_v[k-1];
                r_idx[k] <= r_idx[k-1];
            end
            r_ram_v       <= r_v[c_SR-1];
            o_rdata_valid <= r_ram_v;
            if (r_ram_v) begin
                o_rdata <= r_ram_q;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/ddr2_local_resp.sv
`default_nettype none
// =============================================================================
// Module : ddr2_local_resp
// DDR2 local-interface responder: init delay, ready throttling, RAM-backed
// fixed-latency reads. Option macro DDR2_RESP_RAND_STALL_EN adds LFSR stalls.
// Rev    : 1.0
// =============================================================================
module ddr2_local_resp
    import ddr2_resp_pkg::*;
#(
    parameter int ADDR_W      = 24,
    parameter int DATA_W      = 32,
    parameter int MEM_AW      = 10,
    parameter int INIT_CYCLES = 200,
    parameter int RD_LAT      = 4,
    parameter int STALL_GAP   = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] i_local_address,
    input  logic              i_local_write_req,
    input  logic [DATA_W-1:0] i_local_wdata,
    input  logic              i_local_read_req,
    output logic              o_local_ready,
    output logic [DATA_W-1:0] o_local_rdata,
    output logic              o_local_rdata_valid,
    output logic              o_local_init_done,
    output logic              o_proto_err
);

    state_t            r_state, w_state_nxt;
    logic [15:0]       r_init_cnt, r_gap_cnt, w_gap_inc;
    logic [ADDR_W-1:0] r_off, r_addr_q, w_off_eff;
    logic [MEM_AW-1:0] w_idx;
    logic              r_ready, r_init_done, r_proto_err;
    logic              w_ready_nxt, w_init_done_nxt, w_proto_err_nxt;
    logic              w_active, w_wr_acc, w_rd_acc, w_acc, w_conflict;
    logic              w_addr_chg, w_restart, w_gap_hit, w_rand_stall;

    assign w_active   = (r_state != ST_INIT);
    assign w_wr_acc   = w_active && r_ready && i_local_write_req;
    assign w_rd_acc   = w_active && r_ready && i_local_read_req && !i_local_write_req;
    assign w_acc      = w_wr_acc || w_rd_acc;
    assign w_conflict = w_active && i_local_write_req && i_local_read_req;
    assign w_addr_chg = (i_local_address != r_addr_q);

    // Offset restarts on a new burst: from IDLE, on an address change, or on a type switch
    always_comb begin
        w_restart = 1'b1;
        unique case (r_state)
            ST_WR:   w_restart = w_addr_chg || !i_local_write_req;
            ST_RD:   w_restart = w_addr_chg || !i_local_read_req || i_local_write_req;
            default: w_restart = 1'b1;
        endcase
    end

    assign w_off_eff = w_restart ? '0 : r_off;
    assign w_idx     = i_local_address[MEM_AW-1:0] + w_off_eff[MEM_AW-1:0];
    assign w_gap_inc = r_gap_cnt + 16'd1;
    assign w_gap_hit = (STALL_GAP > 0) && w_acc && (w_gap_inc == 16'(STALL_GAP));

`ifdef DDR2_RESP_RAND_STALL_EN
    logic [15:0] r_lfsr, w_lfsr_nxt;
    assign w_lfsr_nxt   = lfsr_step(r_lfsr);
    // Ready is registered, so judge the stall on the value the LFSR will hold
    assign w_rand_stall = (w_lfsr_nxt[2:0] == 3'b000);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lfsr <= LFSR_SEED;
        end else begin
            r_lfsr <= w_lfsr_nxt;
        end
    end
`else
    assign w_rand_stall = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_INIT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_INIT: if (r_init_cnt == 16'(INIT_CYCLES - 1)) w_state_nxt = ST_IDLE;
            ST_IDLE: begin
                if (i_local_write_req)     w_state_nxt = ST_WR;
                else if (i_local_read_req) w_state_nxt = ST_RD;
            end
            ST_WR:   if (!i_local_write_req) w_state_nxt = ST_IDLE;
            ST_RD:   if (!i_local_read_req)  w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_INIT;
        endcase
    end

    always_comb begin
        w_init_done_nxt = (w_state_nxt != ST_INIT);
        w_ready_nxt     = (w_state_nxt != ST_INIT) && !w_gap_hit && !w_rand_stall;
        w_proto_err_nxt = r_proto_err || w_conflict;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_init_cnt  <= '0;
            r_gap_cnt   <= '0;
            r_off       <= '0;
            r_addr_q    <= '0;
            r_ready     <= 1'b0;
            r_init_done <= 1'b0;
            r_proto_err <= 1'b0;
        end else begin
            if (r_state == ST_INIT) begin
                r_init_cnt <= r_init_cnt + 16'd1;
            end
            if (w_gap_hit) begin
                r_gap_cnt <= '0;
            end else if (w_acc) begin
                r_gap_cnt <= w_gap_inc;
            end
            r_off       <= w_acc ? (w_off_eff + ADDR_W'(1)) : w_off_eff;
            r_addr_q    <= i_local_address;
            r_ready     <= w_ready_nxt;
            r_init_done <= w_init_done_nxt;
            r_proto_err <= w_proto_err_nxt;
        end
    end

    assign o_local_ready     = r_ready;
    assign o_local_init_done = r_init_done;
    assign o_proto_err       = r_proto_err;

    ddr2_resp_rdpipe #(
        .DATA_W (DATA_W),
        .MEM_AW (MEM_AW),
        .RD_LAT (RD_LAT)
    ) u_rdpipe (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_we          (w_wr_acc),
        .i_re          (w_rd_acc),
        .i_idx         (w_idx),
        .i_wdata       (i_local_wdata),
        .o_rdata       (o_local_rdata),
        .o_rdata_valid (o_local_rdata_valid)
    );

endmodule
`default_nettype wire

// File: tb/tb_ddr2_local_resp.sv
`default_nettype none
// =============================================================================
// Module : tb_ddr2_local_resp
// Self-checking bench: per-cycle comparison against a behavioural model.
// Rev    : 1.0
// =============================================================================
`timescale 1ns/1ps
module tb_ddr2_local_resp;

    localparam int ADDR_W      = 24;
    localparam int DATA_W      = 32;
    localparam int MEM_AW      = 10;
    localparam int INIT_CYCLES = 200;
    localparam int RD_LAT      = 4;
    localparam int STALL_GAP   = 3;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [ADDR_W-1:0] i_addr = '0;
    logic              i_wr = 1'b0;
    logic              i_rd = 1'b0;
    logic [DATA_W-1:0] i_wdata = '0;
    logic              o_ready, o_valid, o_init, o_perr;
    logic [DATA_W-1:0] o_rdata;

    always #5 clk = ~clk;

    ddr2_local_resp #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_AW(MEM_AW),
        .INIT_CYCLES(INIT_CYCLES), .RD_LAT(RD_LAT), .STALL_GAP(STALL_GAP)
    ) u_dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .i_local_address     (i_addr),
        .i_local_write_req   (i_wr),
        .i_local_wdata       (i_wdata),
        .i_local_read_req    (i_rd),
        .o_local_ready       (o_ready),
        .o_local_rdata       (o_rdata),
        .o_local_rdata_valid (o_valid),
        .o_local_init_done   (o_init),
        .o_proto_err         (o_perr)
    );

    int n_total = 0;
    int n_bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: edges since reset release, beat acceptance from the
    // model's own ready, word store keyed by aliased address, due-time read queue.
    typedef struct { int due; logic [31:0] d; } rd_t;
    int                m_edges = 0;
    int                m_gap   = 0;
    bit                m_ready = 1'b0, m_init = 1'b0, m_perr = 1'b0;
    bit                mw, mr, mhit;
    int                mkey;
    logic [31:0]       m_mem [int];
    rd_t               m_q[$];
    logic [ADDR_W-1:0] drv_addr = '0;
    logic [31:0]       cap[$];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_edges = 0; m_gap = 0;
            m_ready = 1'b0; m_init = 1'b0; m_perr = 1'b0;
            m_q.delete();
        end else begin
            m_edges++;
            mw   = m_ready && i_wr;
            mr   = m_ready && i_rd && !i_wr;
            if (m_init && i_wr && i_rd) m_perr = 1'b1;
            mkey = int'(drv_addr) % (1 << MEM_AW);
            if (mw) m_mem[mkey] = i_wdata;
            if (mr) m_q.push_back('{m_edges + RD_LAT, m_mem.exists(mkey) ? m_mem[mkey] : 32'hx});
            mhit = 1'b0;
            if (mw || mr) begin
                m_gap++;
                if (m_gap == STALL_GAP) begin
                    m_gap = 0;
                    mhit  = 1'b1;
                end
            end
            m_init  = (m_edges >= INIT_CYCLES);
            m_ready = m_init && !mhit;
        end
    end

    always @(negedge clk) begin
        chk("ready", o_ready, m_ready);
        chk("init_done", o_init, m_init);
        chk("proto_err", o_perr, m_perr);
        if (m_q.size() > 0 && m_q[0].due == m_edges) begin
            chk("rdata_valid", o_valid, 1);
            chk("rdata", o_rdata, m_q[0].d);
            m_q.delete(0);
        end else begin
            chk("rdata_valid", o_valid, 0);
        end
        if (o_valid) cap.push_back(o_rdata);
    end

    task automatic idle(input int n);
        i_wr = 1'b0; i_rd = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic burst(input bit is_wr, input logic [ADDR_W-1:0] base, input int n,
                         input logic [31:0] d0, output int cyc);
        int  i;
        bit  acc;
        i = 0; cyc = 0;
        while (i < n && cyc < 100) begin
            i_addr   = base;
            drv_addr = base + 24'(i);
            i_wr     = is_wr;
            i_rd     = !is_wr;
            i_wdata  = d0 + 32'(i);
            acc      = m_ready;
            @(posedge clk); #1;
            cyc++;
            if (acc) i++;
        end
        i_wr = 1'b0; i_rd = 1'b0;
        if (i < n) chk("burst_timeout", i, n);
    endtask

    task automatic init_check();
        repeat (INIT_CYCLES - 1) @(posedge clk);
        #1;
        chk("init_before", o_init, 0);
        chk("ready_before", o_ready, 0);
        @(posedge clk); #1;
        chk("init_at", o_init, 1);
        chk("ready_at", o_ready, 1);
    endtask

    task automatic reset_values();
        chk("rst_ready", o_ready, 0);
        chk("rst_rdata", o_rdata, 0);
        chk("rst_valid", o_valid, 0);
        chk("rst_init", o_init, 0);
        chk("rst_perr", o_perr, 0);
    endtask

    task automatic read_back(input logic [ADDR_W-1:0] base, input int n, input logic [31:0] d0,
                             input string nm);
        int cyc;
        cap.delete();
        burst(1'b0, base, n, 32'h0, cyc);
        idle(RD_LAT + 3);
        chk({nm, "_count"}, cap.size(), n);
        for (int k = 0; k < n && k < cap.size(); k++) chk(nm, cap[k], d0 + 32'(k));
    endtask

    initial begin
        int cyc;
        int w;
        repeat (3) @(posedge clk);
        #1;
        reset_values();
        rst_n = 1'b1;
        init_check();

        // Backpressure: ready drops after beats 3, 6, 9
        burst(1'b1, 24'h000300, 9, 32'h3000_0000, cyc);
        chk("wr9_cycles", cyc, 11);
        chk("ready_after_beat9", o_ready, 0);
        idle(2);
        read_back(24'h000300, 9, 32'h3000_0000, "rd9");

        // Plain 8-beat write then read
        burst(1'b1, 24'h000100, 8, 32'h1000_0000, cyc);
        idle(2);
        read_back(24'h000100, 8, 32'h1000_0000, "rd8");
        chk("perr_clean", o_perr, 0);

        // Aliasing above MEM_AW bits
        burst(1'b1, 24'h000400, 1, 32'hDEAD_BEEF, cyc);
        idle(2);
        read_back(24'h000000, 1, 32'hDEAD_BEEF, "alias");

        // Address wrap: FFFFFE..000001 land on 3FE,3FF,000,001
        burst(1'b1, 24'hFFFFFE, 4, 32'hA000_0000, cyc);
        idle(2);
        read_back(24'h0003FE, 4, 32'hA000_0000, "wrap");

        // Conflict: both requests in one accepted cycle
        w = 0;
        while (!m_ready && w < 10) begin @(posedge clk); #1; w++; end
        i_addr = 24'h000200; drv_addr = 24'h000200; i_wdata = 32'hCAFE_F00D;
        i_wr = 1'b1; i_rd = 1'b1;
        @(posedge clk); #1;
        idle(RD_LAT + 3);
        chk("perr_set", o_perr, 1);
        read_back(24'h000200, 1, 32'hCAFE_F00D, "conflict");
        chk("perr_sticky", o_perr, 1);

        // Reset two cycles after a 4-beat read is accepted
        burst(1'b0, 24'h000100, 4, 32'h0, cyc);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        cap.delete();
        repeat (3) @(posedge clk);
        #1;
        reset_values();
        rst_n = 1'b1;
        init_check();
        idle(4);
        chk("no_valid_after_reset", cap.size(), 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, total=%0d bad=%0d", n_total, n_bad);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
